// File: rtl/vga_text_pkg.sv
// Shared constants for the VGA text overlay: glyph codes, glyph cell size and
// the ROM address used for blank cells.
package vga_text_pkg;

  localparam logic [3:0] CH_BLANK     = 4'hA;
  localparam logic [3:0] CH_COLON     = 4'hB;
  localparam logic [3:0] CH_SLASH     = 4'hC;
  localparam logic [3:0] CH_MAX_LEGAL = 4'hC;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [7:0] BLANK_DIR = 8'hA0;

  function automatic logic code_legal(input logic [3:0] code);
    return code <= CH_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/vga_text_charbuf.sv
// Character line buffer: NCHAR 4-bit glyph codes, one write port with range
// check, and a combinational read port addressed by character index.
module vga_text_charbuf
  import vga_text_pkg::*;
#(
  parameter int NCHAR = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_char,
  input  logic [2:0] rd_addr,
  output logic [3:0] rd_char
);

  logic [3:0] mem [NCHAR];

  // Addresses without a matching slot simply hit no entry, so they are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCHAR; i++) mem[i] <= CH_BLANK;
    end else begin
      for (int i = 0; i < NCHAR; i++) begin
        if (wr_en && wr_addr == 3'(i)) mem[i] <= wr_char;
      end
    end
  end

  always_comb begin
    rd_char = CH_BLANK;
    for (int i = 0; i < NCHAR; i++) begin
      if (rd_addr == 3'(i)) rd_char = mem[i];
    end
  end

endmodule

// File: rtl/vga_text_render.sv
// Three-stage text overlay: window decode, glyph ROM addressing, pixel
// serialisation, with matching sync delay. Optional blinking cursor under
// VGA_TEXT_CURSOR_BLINK_EN (adds the cursor_pos input).
module vga_text_render
  import vga_text_pkg::*;
#(
  parameter int         X0       = 256,
  parameter int         Y0       = 232,
  parameter int         NCHAR    = 8,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_char,
`ifdef VGA_TEXT_CURSOR_BLINK_EN
  input  logic [2:0] cursor_pos,
`endif
  output logic [7:0] rom_dir,
  input  logic [7:0] rom_data,
  output logic [7:0] rgb,
  output logic       hsync_o,
  output logic       vsync_o
);

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + GLYPH_W * NCHAR);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + GLYPH_H);

  logic       win_c;
  logic [5:0] dx_c;
  logic [3:0] dy_c;

  logic       s1_win, s1_von, s1_hs, s1_vs;
  logic [2:0] s1_col, s1_cidx;
  logic [3:0] s1_row;
  logic       s2_win, s2_von, s2_hs, s2_vs;
  logic [2:0] s2_col;
  logic [3:0] rd_char;
  logic       inv;

  // Only the low bits of the offsets are used, and only when the window
  // compare passes, so a wrapped subtraction outside the window is harmless.
  always_comb begin
    win_c = video_on && pixel_x >= X_LO && pixel_x < X_HI &&
            pixel_y >= Y_LO && pixel_y < Y_HI;
    dx_c  = pixel_x[5:0] - X_LO[5:0];
    dy_c  = pixel_y[3:0] - Y_LO[3:0];
  end

  vga_text_charbuf #(.NCHAR(NCHAR)) u_charbuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .rd_addr (s1_cidx),
    .rd_char (rd_char)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_win  <= 1'b0;
      s1_von  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_col  <= '0;
      s1_cidx <= '0;
      s1_row  <= '0;
      s2_win  <= 1'b0;
      s2_von  <= 1'b0;
      s2_hs   <= 1'b1;
      s2_vs   <= 1'b1;
      s2_col  <= '0;
      rom_dir <= BLANK_DIR;
      rgb     <= 8'h00;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      s1_win  <= win_c;
      s1_von  <= video_on;
      s1_hs   <= hsync_i;
      s1_vs   <= vsync_i;
      s1_col  <= dx_c[2:0];
      s1_cidx <= dx_c[5:3];
      s1_row  <= dy_c;

      s2_win  <= s1_win;
      s2_von  <= s1_von;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_col  <= s1_col;
      rom_dir <= (s1_win && code_legal(rd_char)) ? {rd_char, s1_row} : BLANK_DIR;

      if (!s2_von)
        rgb <= 8'h00;
      else if (s2_win && (rom_data[3'd7 - s2_col] ^ inv))
        rgb <= FG_COLOR;
      else
        rgb <= BG_COLOR;
      hsync_o <= s2_hs;
      vsync_o <= s2_vs;
    end
  end

`ifdef VGA_TEXT_CURSOR_BLINK_EN
  logic [4:0] frame_cnt;
  logic       vs_prev, s1_cur, s2_cur, cursor_ok;

  assign cursor_ok = (NCHAR >= 8) || (int'(cursor_pos) < NCHAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      vs_prev   <= 1'b1;
      s1_cur    <= 1'b0;
      s2_cur    <= 1'b0;
    end else begin
      vs_prev <= vsync_i;
      if (vs_prev && !vsync_i) frame_cnt <= frame_cnt + 5'd1;
      s1_cur <= cursor_ok && (dx_c[5:3] == cursor_pos);
      s2_cur <= s1_cur;
    end
  end

  assign inv = s2_cur & frame_cnt[4];
`else
  assign inv = 1'b0;
`endif

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render with a small glyph ROM model attached.
module tb_vga_text_render;
  import vga_text_pkg::*;

  localparam int         X0    = 256;
  localparam int         Y0    = 232;
  localparam int         NCHAR = 8;
  localparam logic [7:0] FG    = 8'hFC;
  localparam logic [7:0] BG    = 8'h03;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, hsync_i, vsync_i;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_char;
  logic [7:0] rom_dir, rom_data, rgb;
  logic       hsync_o, vsync_o;
`ifdef VGA_TEXT_CURSOR_BLINK_EN
  logic [2:0] cursor_pos = 3'd2;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] dir;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t q1, q2, chk_dir, chk_pix;

  vga_text_render #(
    .X0(X0), .Y0(Y0), .NCHAR(NCHAR), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .video_on (video_on),
    .hsync_i  (hsync_i),
    .vsync_i  (vsync_i),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_char  (wr_char),
`ifdef VGA_TEXT_CURSOR_BLINK_EN
    .cursor_pos (cursor_pos),
`endif
    .rom_dir  (rom_dir),
    .rom_data (rom_data),
    .rgb      (rgb),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o)
  );

  always #5 clk = ~clk;

  // Glyph '1': row 1 = 00000110, other rows = 00011000; codes D-F all set so
  // an unforced illegal code would light pixels.
  function automatic logic [7:0] rom_model(input logic [7:0] dir);
    if (dir == 8'h11) return 8'h06;
    if (dir[7:4] == 4'h1) return 8'h18;
    if (dir[7:4] >= 4'hD) return 8'hFF;
    return 8'h00;
  endfunction

  always_comb rom_data = rom_model(rom_dir);

  task automatic step(input int x, input int y, input logic von, input logic hs,
                      input logic vs, input logic we, input logic [2:0] wa,
                      input logic [3:0] wc, input logic [7:0] edir, input logic [7:0] ergb);
    exp_t cur;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_i  = hs;
    vsync_i  = vs;
    wr_en    = we;
    wr_addr  = wa;
    wr_char  = wc;
    cur.v = 1'b1; cur.dir = edir; cur.rgb = ergb; cur.hs = hs; cur.vs = vs;
    @(negedge clk);
    chk_dir = q1;
    chk_pix = q2;
    q2 = q1;
    q1 = cur;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_x = 10'(X0); pixel_y = 10'(Y0);
    video_on = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_char = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rgb, rom_dir, hsync_o, vsync_o} !== {8'h00, 8'hA0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset: rgb=%h rom_dir=%h hs=%b vs=%b expected 00 a0 1 1",
               rgb, rom_dir, hsync_o, vsync_o);
    end
    reset = 1'b0;
    q1 = '0;
    q2 = '0;
  endtask

  task automatic test_empty_scan();
    for (int y = Y0; y < Y0 + 16; y++) begin
      for (int x = X0 - 1; x <= X0 + 64; x++) begin
        logic [9:0] xv;
        logic inw;
        xv  = 10'(x);
        inw = (x >= X0) && (x < X0 + 64);
        step(x, y, 1'b1, xv[2:0] != 3'd3, !(y == Y0 + 7 && x == X0 + 3), 1'b0, 3'd0, 4'd0,
             inw ? {4'hA, 4'(y - Y0)} : 8'hA0, BG);
        if (chk_dir.v) begin
          checks++;
          if (rom_dir !== chk_dir.dir) begin
            errors++;
            $display("FAIL empty_dir: rom_dir=%h expected %h", rom_dir, chk_dir.dir);
          end
        end
        if (chk_pix.v) begin
          checks++;
          if ({rgb, hsync_o, vsync_o} !== {chk_pix.rgb, chk_pix.hs, chk_pix.vs}) begin
            errors++;
            $display("FAIL empty_pix: rgb=%h hs=%b vs=%b expected %h %b %b",
                     rgb, hsync_o, vsync_o, chk_pix.rgb, chk_pix.hs, chk_pix.vs);
          end
        end
      end
    end
  endtask

  task automatic test_digit();
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 4'd1, 8'hA0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      int r;
      r = (k == 0) ? 1 : 3;
      for (int x = X0 - 2; x <= X0 + 9; x++) begin
        logic [7:0] edir, ergb;
        if (x < X0) edir = 8'hA0;
        else if (x < X0 + 8) edir = {4'h1, 4'(r)};
        else edir = {4'hA, 4'(r)};
        if (r == 1) ergb = (x == X0 + 5 || x == X0 + 6) ? FG : BG;
        else        ergb = (x == X0 + 3 || x == X0 + 4) ? FG : BG;
        step(x, Y0 + r, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, edir, ergb);
        if (chk_dir.v) begin
          checks++;
          if (rom_dir !== chk_dir.dir) begin
            errors++;
            $display("FAIL digit_dir: rom_dir=%h expected %h", rom_dir, chk_dir.dir);
          end
        end
        if (chk_pix.v) begin
          checks++;
          if ({rgb, hsync_o, vsync_o} !== {chk_pix.rgb, chk_pix.hs, chk_pix.vs}) begin
            errors++;
            $display("FAIL digit_pix: rgb=%h hs=%b vs=%b expected %h %b %b",
                     rgb, hsync_o, vsync_o, chk_pix.rgb, chk_pix.hs, chk_pix.vs);
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 4'hE, 8'hA0, 8'h00);
    for (int x = X0 + 54; x <= X0 + 63; x++) begin
      step(x, Y0 + 2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0,
           (x < X0 + 56) ? 8'hA2 : 8'hA0, BG);
      if (chk_dir.v) begin
        checks++;
        if (rom_dir !== chk_dir.dir) begin
          errors++;
          $display("FAIL illegal_dir: rom_dir=%h expected %h", rom_dir, chk_dir.dir);
        end
      end
      if (chk_pix.v) begin
        checks++;
        if ({rgb, hsync_o, vsync_o} !== {chk_pix.rgb, chk_pix.hs, chk_pix.vs}) begin
          errors++;
          $display("FAIL illegal_pix: rgb=%h hs=%b vs=%b expected %h %b %b",
                   rgb, hsync_o, vsync_o, chk_pix.rgb, chk_pix.hs, chk_pix.vs);
        end
      end
    end
  endtask

  // The second vector's write lands on the edge where the first vector reads
  // slot 3, so the first sees blank and the second sees the digit.
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      int x;
      logic we;
      logic [7:0] edir, ergb;
      x    = (i < 2) ? X0 + 29 : ((i == 2) ? X0 + 30 : 0);
      we   = (i == 1);
      edir = (i == 0) ? 8'hA1 : ((i < 3) ? 8'h11 : 8'hA0);
      ergb = (i == 0) ? BG : ((i < 3) ? FG : 8'h00);
      step(x, (i < 3) ? Y0 + 1 : 0, i < 3, 1'b1, 1'b1, we, 3'd3, 4'd1, edir, ergb);
      if (chk_dir.v) begin
        checks++;
        if (rom_dir !== chk_dir.dir) begin
          errors++;
          $display("FAIL collide_dir: rom_dir=%h expected %h", rom_dir, chk_dir.dir);
        end
      end
      if (chk_pix.v) begin
        checks++;
        if ({rgb, hsync_o, vsync_o} !== {chk_pix.rgb, chk_pix.hs, chk_pix.vs}) begin
          errors++;
          $display("FAIL collide_pix: rgb=%h hs=%b vs=%b expected %h %b %b",
                   rgb, hsync_o, vsync_o, chk_pix.rgb, chk_pix.hs, chk_pix.vs);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    int         bx   [9] = '{X0 - 1, X0 + 64, X0, X0, X0 + 5, X0 + 5, X0 + 7, X0 + 63, 0};
    int         by   [9] = '{Y0 + 1, Y0 + 1, Y0 + 16, Y0 - 1, Y0 + 1, Y0 + 1, Y0 + 15, Y0 + 15, 0};
    logic       bv   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] bdir [9] = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h11, 8'h1F, 8'hA0, 8'hA0};
    logic [7:0] brgb [9] = '{BG, BG, BG, BG, 8'h00, FG, BG, BG, 8'h00};
    for (int i = 0; i < 9; i++) begin
      step(bx[i], by[i], bv[i], 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, bdir[i], brgb[i]);
      if (chk_dir.v) begin
        checks++;
        if (rom_dir !== chk_dir.dir) begin
          errors++;
          $display("FAIL bound_dir: rom_dir=%h expected %h", rom_dir, chk_dir.dir);
        end
      end
      if (chk_pix.v) begin
        checks++;
        if ({rgb, hsync_o, vsync_o} !== {chk_pix.rgb, chk_pix.hs, chk_pix.vs}) begin
          errors++;
          $display("FAIL bound_pix: rgb=%h hs=%b vs=%b expected %h %b %b",
                   rgb, hsync_o, vsync_o, chk_pix.rgb, chk_pix.hs, chk_pix.vs);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    step(X0 + 5, Y0 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h11, FG);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rgb, rom_dir, hsync_o, vsync_o} !== {8'h00, 8'hA0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL midreset: rgb=%h rom_dir=%h hs=%b vs=%b expected 00 a0 1 1",
               rgb, rom_dir, hsync_o, vsync_o);
    end
    reset = 1'b0;
    q1 = '0;
    q2 = '0;
    for (int i = 0; i < 4; i++) begin
      logic von;
      von = (i < 2);
      step(von ? X0 + 5 + i : 0, von ? Y0 + 1 : 0, von, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0,
           von ? 8'hA1 : 8'hA0, von ? BG : 8'h00);
      if (chk_dir.v) begin
        checks++;
        if (rom_dir !== chk_dir.dir) begin
          errors++;
          $display("FAIL resume_dir: rom_dir=%h expected %h", rom_dir, chk_dir.dir);
        end
      end
      if (chk_pix.v) begin
        checks++;
        if ({rgb, hsync_o, vsync_o} !== {chk_pix.rgb, chk_pix.hs, chk_pix.vs}) begin
          errors++;
          $display("FAIL resume_pix: rgb=%h hs=%b vs=%b expected %h %b %b",
                   rgb, hsync_o, vsync_o, chk_pix.rgb, chk_pix.hs, chk_pix.vs);
        end
      end
    end
  endtask

`ifdef VGA_TEXT_CURSOR_BLINK_EN
  task automatic test_cursor();
    test_reset();
    for (int phase = 0; phase < 2; phase++) begin
      for (int f = 0; f < 16; f++) begin
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'hA0, 8'h00);
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 8'hA0, 8'h00);
      end
      for (int x = X0 + 14; x <= X0 + 25; x++) begin
        logic slot2;
        slot2 = (x >= X0 + 16) && (x < X0 + 24);
        step(x, Y0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 8'hA0,
             (slot2 && phase == 0) ? FG : BG);
        if (chk_pix.v) begin
          checks++;
          if (rgb !== chk_pix.rgb) begin
            errors++;
            $display("FAIL cursor_pix: rgb=%h expected %h", rgb, chk_pix.rgb);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    q1 = '0;
    q2 = '0;
    chk_dir = '0;
    chk_pix = '0;
    test_reset();
    test_empty_scan();
    test_digit();
    test_illegal();
    test_back_to_back();
    test_boundaries();
    test_mid_reset();
`ifdef VGA_TEXT_CURSOR_BLINK_EN
    test_cursor();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
